relu_unit: RTL and testbench

Pipelined signed ReLU activation stage for the BNN datapath. Takes one signed accumulator word per cycle with a valid strobe, clamps negative values to zero, and can also clip large positives to an upper bound. Output is registered and qualified by a matching valid strobe. The stage sits between the convolution/accumulate stage and the binarize/pool stages.

---
 rtl/relu_unit_if.sv | 26 ++
 rtl/relu_unit.sv | 62 ++++++
 tb/tb_relu_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/relu_unit_if.sv
// Sample stream into and out of the ReLU stage: a data word qualified by a
// valid strobe in each direction, with no backpressure.
interface relu_unit_if #(
  parameter int DATA_W = 32
);
  logic signed [DATA_W-1:0] din;
  logic                     ivalid;
  logic                     ovalid;
  logic signed [DATA_W-1:0] dout;

  // Producer side: drives samples, observes results.
  modport master (
    output din,
    output ivalid,
    input  ovalid,
    input  dout
  );

  // ReLU stage side: consumes samples, produces results.
  modport slave (
    input  din,
    input  ivalid,
    output ovalid,
    output dout
  );
endinterface

// File: rtl/relu_unit.sv
// Pipelined signed ReLU (optionally ReLU-N) stage. The activation is
// evaluated in front of the first register; the remaining stages only
// delay the result so that latency is exactly PIPE_STAGES cycles.
module relu_unit #(
  parameter int                       DATA_W      = 32,
  parameter int                       PIPE_STAGES = 1,
  parameter bit                       CLIP_EN     = 1'b0,
  parameter logic signed [DATA_W-1:0] CLIP_MAX    = {1'b0, {(DATA_W-1){1'b1}}}
) (
  input  logic        clk,
  input  logic        rst,
  relu_unit_if.slave  bus
);

  logic signed [DATA_W-1:0] relu_d;

  // Activation: negatives clamp to zero, optional upper clip on the rest.
  always_comb begin
    relu_d = bus.din;
    if (bus.din[DATA_W-1]) begin
      relu_d = '0;
    end else if (CLIP_EN && (bus.din > CLIP_MAX)) begin
      relu_d = CLIP_MAX;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      logic signed [DATA_W-1:0] in_data;
      logic                     in_valid;
      logic signed [DATA_W-1:0] data_q;
      logic                     valid_q;

      if (gi == 0) begin : g_head
        assign in_data  = relu_d;
        assign in_valid = bus.ivalid;
      end else begin : g_tail
        assign in_data  = g_stage[gi-1].data_q;
        assign in_valid = g_stage[gi-1].valid_q;
      end

      // Data loads only with a valid sample, so idle cycles leave the
      // last result visible; the valid bit simply follows its input.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid;
          if (in_valid) begin
            data_q <= in_data;
          end
        end
      end
    end
  endgenerate

  assign bus.dout   = g_stage[PIPE_STAGES-1].data_q;
  assign bus.ovalid = g_stage[PIPE_STAGES-1].valid_q;

endmodule

// File: tb/tb_relu_unit.sv
// Bench for relu_unit: five instances (PIPE_STAGES 1..4, plus a ReLU-6
// clipping variant) share one stimulus stream. A scoreboard per instance
// checks timing and values every cycle; directed tables and sequences
// check the documented corner cases.
module tb_relu_unit;
  localparam int W  = 32;
  localparam int ND = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_unit_if #(.DATA_W(W)) bus1 ();
  relu_unit_if #(.DATA_W(W)) bus2 ();
  relu_unit_if #(.DATA_W(W)) bus3 ();
  relu_unit_if #(.DATA_W(W)) bus4 ();
  relu_unit_if #(.DATA_W(W)) busc ();

  relu_unit #(.DATA_W(W), .PIPE_STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  relu_unit #(.DATA_W(W), .PIPE_STAGES(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  relu_unit #(.DATA_W(W), .PIPE_STAGES(3)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  relu_unit #(.DATA_W(W), .PIPE_STAGES(4)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  relu_unit #(.DATA_W(W), .PIPE_STAGES(1), .CLIP_EN(1'b1), .CLIP_MAX(32'sd6))
    uc (.clk(clk), .rst(rst), .bus(busc.slave));

  logic         ov [ND];
  logic [W-1:0] dv [ND];
  assign ov[0] = bus1.ovalid;  assign dv[0] = bus1.dout;
  assign ov[1] = bus2.ovalid;  assign dv[1] = bus2.dout;
  assign ov[2] = bus3.ovalid;  assign dv[2] = bus3.dout;
  assign ov[3] = bus4.ovalid;  assign dv[3] = bus4.dout;
  assign ov[4] = busc.ovalid;  assign dv[4] = busc.dout;

  int pipe_of [ND] = '{1, 2, 3, 4, 1};
  bit clip_of [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } exp_t;

  exp_t         sbq  [ND][$];
  logic [W-1:0] hold [ND];
  int           ec;
  int           n_chk;
  int           n_pass;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp_relu;
    logic [W-1:0] exp_clip;
  } vec_t;

  vec_t tbl [11];

  // Reference: ReLU, or ReLU-6 for the clipping instance.
  function automatic logic [W-1:0] ref_relu(logic [W-1:0] x, bit clip);
    if (x[W-1]) return '0;
    if (clip && ($signed(x) > 32'sd6)) return 32'd6;
    return x;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [W-1:0] b2w(logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  // One clock cycle: apply inputs, take the edge, log what the DUTs owe us.
  task automatic step(logic [W-1:0] d, bit v, bit r);
    exp_t e;
    rst = r;
    bus1.din = d;  bus1.ivalid = v;
    bus2.din = d;  bus2.ivalid = v;
    bus3.din = d;  bus3.ivalid = v;
    bus4.din = d;  bus4.ivalid = v;
    busc.din = d;  busc.ivalid = v;
    @(posedge clk);
    ec++;
    for (int i = 0; i < ND; i++) begin
      if (r) begin
        sbq[i].delete();
        hold[i] = '0;
      end else if (v) begin
        e.val = ref_relu(d, clip_of[i]);
        e.due = ec + pipe_of[i] - 1;
        sbq[i].push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // Scoreboard: every cycle, ovalid must match what is due, data must match
  // the queued result, and dout must hold its last value while idle.
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      bit e;
      e = (sbq[i].size() > 0) && (sbq[i][0].due == ec);
      chk($sformatf("sb_ovalid[%0d]@%0d", i, ec), b2w(ov[i]), b2w(e));
      if (ov[i] && e) chk($sformatf("sb_dout[%0d]@%0d", i, ec), dv[i], sbq[i][0].val);
      if (e) void'(sbq[i].pop_front());
      if (ov[i]) hold[i] = dv[i];
      else chk($sformatf("sb_hold[%0d]@%0d", i, ec), dv[i], hold[i]);
    end
  end

  initial begin
    logic [W-1:0] d;
    bit           v;
    bit           r;

    ec = 0; n_chk = 0; n_pass = 0;
    for (int i = 0; i < ND; i++) hold[i] = '0;

    tbl[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[1]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    tbl[3]  = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0006};
    tbl[5]  = '{32'd1234,      32'd1234,      32'h0000_0006};
    tbl[6]  = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000};
    tbl[7]  = '{32'd3,         32'd3,         32'd3};
    tbl[8]  = '{32'd6,         32'd6,         32'd6};
    tbl[9]  = '{32'd7,         32'd7,         32'd6};
    tbl[10] = '{32'd1000,      32'd1000,      32'd6};

    // Reset held two cycles with a valid sample on the input.
    repeat (2) begin
      step(32'd5, 1'b1, 1'b1);
      chk("rst_ovalid", b2w(ov[0]), b2w(1'b0));
      chk("rst_dout", dv[0], 32'd0);
    end
    step(32'd5, 1'b1, 1'b0);
    chk("post_rst_ovalid", b2w(ov[0]), b2w(1'b1));
    chk("post_rst_dout", dv[0], 32'd5);

    // Back-to-back sign / clip vectors, single-stage instances.
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].din, 1'b1, 1'b0);
      chk($sformatf("tbl_ovalid[%0d]", k), b2w(ov[0]), b2w(1'b1));
      chk($sformatf("tbl_relu[%0d]", k), dv[0], tbl[k].exp_relu);
      chk($sformatf("tbl_clip[%0d]", k), dv[4], tbl[k].exp_clip);
    end
    step(32'd0, 1'b0, 1'b0);

    // Valid gating: invalid samples must not move dout.
    step(32'd7, 1'b1, 1'b0);
    chk("gate_ovalid0", b2w(ov[0]), b2w(1'b1));
    chk("gate_dout0", dv[0], 32'd7);
    step(32'hFFFF_FFFD, 1'b0, 1'b0);
    chk("gate_ovalid1", b2w(ov[0]), b2w(1'b0));
    chk("gate_dout1", dv[0], 32'd7);
    step(32'd9, 1'b0, 1'b0);
    chk("gate_ovalid2", b2w(ov[0]), b2w(1'b0));
    chk("gate_dout2", dv[0], 32'd7);

    // Mid-stream reset on the 3-stage instance, then one fresh sample.
    step(32'd11, 1'b1, 1'b0);
    step(32'd12, 1'b1, 1'b0);
    step(32'd13, 1'b1, 1'b0);
    step(32'd99, 1'b1, 1'b1);
    chk("mid_rst_ovalid", b2w(ov[2]), b2w(1'b0));
    chk("mid_rst_dout", dv[2], 32'd0);
    step(32'd42, 1'b1, 1'b0);
    chk("mid_p3_early", b2w(ov[2]), b2w(1'b0));
    for (int k = 0; k < 5; k++) begin
      step(32'd0, 1'b0, 1'b0);
      chk($sformatf("mid_p3_ovalid[%0d]", k), b2w(ov[2]), b2w(k == 1));
      if (k >= 1) chk($sformatf("mid_p3_dout[%0d]", k), dv[2], 32'd42);
    end

    // Random stream with occasional resets and corner values.
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 9))
        0:       d = 32'h8000_0000;
        1:       d = 32'h7FFF_FFFF;
        2:       d = 32'd0;
        3:       d = 32'(32'd4 + $urandom_range(0, 4));
        default: d = $urandom;
      endcase
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 499) == 0);
      step(d, v, r);
    end

    // Drain and confirm nothing owed is left behind.
    repeat (6) step(32'd0, 1'b0, 1'b0);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("drain_empty[%0d]", i), 32'(sbq[i].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
